pmu_event_conditioner: RTL and testbench

// - Upstream stage of PMU_raw: conditions raw SoC event lines before they enter events_i / crossbar.
// - Per-event mode: off, level, rising-edge pulse, or divided level.
//   "Divided level" emits 1 pulse per (div+1) active cycles.
// - Registered output, so PMU counters see clean single-clock qualified events.

---
 rtl/pmu_event_conditioner_if.sv | 25 ++
 rtl/pmu_event_conditioner.sv | 90 +++++++++
 tb/tb_pmu_event_conditioner.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pmu_event_conditioner_if.sv
// Bundle of the conditioner's event, configuration and status signals.
// The master side drives the raw events and configuration; the slave side is the conditioner.
interface pmu_event_conditioner_if #(
  parameter int N_SOC_EV = 128,
  parameter int DIV_W    = 8
);
  logic [N_SOC_EV-1:0]   events_i;
  logic [2*N_SOC_EV-1:0] mode_i;
  logic [DIV_W-1:0]      div_i;
  logic                  en_i;
  logic                  clear_i;
  logic                  seen_clr_i;
  logic [N_SOC_EV-1:0]   events_o;
  logic [N_SOC_EV-1:0]   seen_o;

  modport master (
    output events_i, mode_i, div_i, en_i, clear_i, seen_clr_i,
    input  events_o, seen_o
  );

  modport slave (
    input  events_i, mode_i, div_i, en_i, clear_i, seen_clr_i,
    output events_o, seen_o
  );
endinterface

// File: rtl/pmu_event_conditioner.sv
// Conditions raw SoC event lines (off / level / rising edge / divided level) into registered PMU events.
// Optional sticky activity vector seen_o is built only when PMU_EVCOND_STICKY_EN is defined.
module pmu_event_conditioner #(
  parameter int N_SOC_EV = 128,
  parameter int DIV_W    = 8
) (
  input logic                     clk_i,
  input logic                     rst_i,
  pmu_event_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_LEVEL = 2'b01,
    MODE_RISE  = 2'b10,
    MODE_DIV   = 2'b11
  } mode_e;

  logic [N_SOC_EV-1:0] events_q, events_d;
  logic [N_SOC_EV-1:0] prev_q;
  logic [DIV_W-1:0]    cnt_q [N_SOC_EV];
  logic [DIV_W-1:0]    cnt_d [N_SOC_EV];
  mode_e               modeK;

  always_comb begin
    events_d = '0;
    modeK    = MODE_OFF;
    for (int k = 0; k < N_SOC_EV; k++) begin
      cnt_d[k] = cnt_q[k];
      modeK    = mode_e'(bus.mode_i[2*k +: 2]);
      case (modeK)
        MODE_OFF:   cnt_d[k] = '0;
        MODE_LEVEL: begin
          events_d[k] = bus.events_i[k];
          cnt_d[k]    = '0;
        end
        MODE_RISE:  begin
          events_d[k] = bus.events_i[k] & ~prev_q[k];
          cnt_d[k]    = '0;
        end
        MODE_DIV:   begin
          // Disabled cycles leave the count untouched so division resumes where it stopped.
          if (bus.en_i && bus.events_i[k]) begin
            if (cnt_q[k] >= bus.div_i) begin
              events_d[k] = 1'b1;
              cnt_d[k]    = '0;
            end else begin
              cnt_d[k] = cnt_q[k] + DIV_W'(1);
            end
          end
        end
        default: cnt_d[k] = '0;
      endcase
      if (bus.clear_i) cnt_d[k] = '0;
    end
    if (!bus.en_i) events_d = '0;
  end

  // Edge history tracks the raw input every cycle, independent of enable and mode.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      events_q <= '0;
      prev_q   <= '0;
      for (int k = 0; k < N_SOC_EV; k++) cnt_q[k] <= '0;
    end else begin
      events_q <= events_d;
      prev_q   <= bus.events_i;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.events_o = events_q;

`ifdef PMU_EVCOND_STICKY_EN
  logic [N_SOC_EV-1:0] seen_q, seen_d;

  // A new event in the clearing cycle wins over the clear.
  assign seen_d = (seen_q & ~{N_SOC_EV{bus.seen_clr_i}}) | events_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) seen_q <= '0;
    else       seen_q <= seen_d;
  end

  assign bus.seen_o = seen_q;
`else
  assign bus.seen_o = '0;
`endif

endmodule

// File: tb/tb_pmu_event_conditioner.sv
// Scoreboard bench for pmu_event_conditioner: a cycle-level reference model queues the
// expected outputs for every driven cycle and an independent monitor compares them.
module tb_pmu_event_conditioner;
  localparam int N     = 128;
  localparam int DIV_W = 8;

  logic clk;
  logic rst;

  pmu_event_conditioner_if #(.N_SOC_EV(N), .DIV_W(DIV_W)) bus ();

  pmu_event_conditioner #(.N_SOC_EV(N), .DIV_W(DIV_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] ev;
    logic [N-1:0] seen;
  } exp_t;

  exp_t scoreQ[$];

  int total = 0;
  int bad   = 0;

  // Current stimulus, copied onto the bus once per cycle.
  logic [N-1:0]     evIn;
  logic [2*N-1:0]   modeIn;
  logic [DIV_W-1:0] divIn;
  logic             enIn, clrIn, seenClrIn, rstIn;

  // Reference model state: per-event count of active cycles since the last divided pulse,
  // the previous raw level of each line, and the sticky activity vector.
  int           activeSince [N];
  logic [N-1:0] prevLevel;
  logic [N-1:0] seenModel;

  task automatic checkOutput(input string name, input logic [N-1:0] actual,
                             input logic [N-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at t=%0t actual=%h expected=%h", name, $time, actual, expected);
    end
  endtask

  // Predict what the outputs will hold after the coming rising edge.
  task automatic modelStep();
    exp_t e;
    int   m;
    logic o;
    e.ev   = '0;
    e.seen = '0;
    if (rstIn) begin
      prevLevel = '0;
      seenModel = '0;
      for (int k = 0; k < N; k++) activeSince[k] = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        m = int'(modeIn[2*k +: 2]);
        o = 1'b0;
        if (m == 1) o = evIn[k];
        else if (m == 2) o = evIn[k] && !prevLevel[k];
        else if (m == 3 && enIn && evIn[k]) begin
          if (activeSince[k] >= int'(divIn)) begin
            o = 1'b1;
            activeSince[k] = 0;
          end else begin
            activeSince[k] = activeSince[k] + 1;
          end
        end
        if (m != 3) activeSince[k] = 0;
        if (clrIn) activeSince[k] = 0;
        e.ev[k] = o && enIn;
      end
      prevLevel = evIn;
`ifdef PMU_EVCOND_STICKY_EN
      seenModel = (seenClrIn ? '0 : seenModel) | e.ev;
`else
      seenModel = '0;
`endif
      e.seen = seenModel;
    end
    scoreQ.push_back(e);
  endtask

  // Drive the current stimulus for n cycles, queuing the expected response for each.
  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst            = rstIn;
      bus.events_i   = evIn;
      bus.mode_i     = modeIn;
      bus.div_i      = divIn;
      bus.en_i       = enIn;
      bus.clear_i    = clrIn;
      bus.seen_clr_i = seenClrIn;
      modelStep();
    end
  endtask

  task automatic setMode(input int k, input logic [1:0] m);
    modeIn[2*k +: 2] = m;
  endtask

  // Monitor: the conditioner presents a fresh output every cycle; compare it against the queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (scoreQ.size() > 0) begin
      e = scoreQ.pop_front();
      checkOutput("events_o", bus.events_o, e.ev);
      checkOutput("seen_o", bus.seen_o, e.seen);
    end
  end

  initial begin
    for (int k = 0; k < N; k++) activeSince[k] = 0;
    prevLevel = '0;
    seenModel = '0;

    // Reset held with every line high in level mode.
    rstIn = 1'b1; evIn = '1; modeIn = {N{2'b01}}; divIn = '0;
    enIn = 1'b1; clrIn = 1'b0; seenClrIn = 1'b0;
    applyStimulus(3);
    rstIn = 1'b0;
    applyStimulus(3);

    // Rising-edge mode on event 5.
    modeIn = '0; setMode(5, 2'b10); evIn = '0;
    applyStimulus(2);
    evIn[5] = 1'b1; applyStimulus(4);
    evIn[5] = 1'b0; applyStimulus(2);

    // Divide by 4 on event 7 over 12 active cycles.
    modeIn = '0; setMode(7, 2'b11); divIn = 8'd3;
    applyStimulus(1);
    evIn[7] = 1'b1; applyStimulus(12);
    evIn[7] = 1'b0; applyStimulus(2);

    // Gating: counter holds while disabled, and an edge during disable is not replayed.
    setMode(5, 2'b10); evIn[7] = 1'b1;
    applyStimulus(2);
    enIn = 1'b0; evIn[5] = 1'b1; applyStimulus(5);
    enIn = 1'b1; applyStimulus(4);
    evIn = '0; applyStimulus(2);

    // Clear and lowered threshold below the running count.
    modeIn = '0; setMode(7, 2'b11); divIn = 8'hFF;
    clrIn = 1'b1; applyStimulus(1);
    clrIn = 1'b0; evIn[7] = 1'b1; applyStimulus(200);
    clrIn = 1'b1; applyStimulus(1);
    clrIn = 1'b0; applyStimulus(5);
    divIn = 8'd2; applyStimulus(4);
    divIn = 8'hFF; applyStimulus(258);
    evIn = '0; applyStimulus(1);

    // Sticky flag on event 9: set, clear racing a new pulse, then clear alone.
    modeIn = '0; setMode(9, 2'b10);
    applyStimulus(1);
    evIn[9] = 1'b1; applyStimulus(1);
    evIn[9] = 1'b0; applyStimulus(2);
    evIn[9] = 1'b1; seenClrIn = 1'b1; applyStimulus(1);
    evIn[9] = 1'b0; seenClrIn = 1'b0; applyStimulus(2);
    seenClrIn = 1'b1; applyStimulus(1);
    seenClrIn = 1'b0; applyStimulus(2);

    // Randomised traffic; modes and threshold are quasi-static and change every 32 cycles.
    for (int i = 0; i < 600; i++) begin
      if (i % 32 == 0) begin
        for (int k = 0; k < N; k++) modeIn[2*k +: 2] = 2'($urandom_range(0, 3));
        divIn = DIV_W'($urandom_range(0, 6));
      end
      for (int k = 0; k < N; k++) evIn[k] = ($urandom_range(0, 2) != 0);
      enIn      = ($urandom_range(0, 9) != 0);
      clrIn     = ($urandom_range(0, 24) == 0);
      seenClrIn = ($urandom_range(0, 7) == 0);
      rstIn     = ($urandom_range(0, 149) == 0);
      applyStimulus(1);
    end
    rstIn = 1'b0;

    // Let the monitor drain the last queued cycles, with a bounded wait.
    for (int i = 0; i < 10 && scoreQ.size() > 0; i++) @(posedge clk);
    #2;
    if (scoreQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain actual=%0d pending expected=0 pending", scoreQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
